// File: rtl/stack_controller_pkg.sv
// Shared definitions for the stack instruction sequencer: opcodes, FSM encoding, widths.
package stack_controller_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_AW = 2;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_PUSH = 2'b00;
    localparam logic [OP_W-1:0] OP_POP  = 2'b01;
    localparam logic [OP_W-1:0] OP_CALL = 2'b10;
    localparam logic [OP_W-1:0] OP_RET  = 2'b11;

    localparam logic [REG_AW-1:0] SP_INDEX = 2'd3;
    localparam logic [DATA_W-1:0] SP_TOP   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_WB_SP,
        ST_WB_REG,
        ST_FAULT
    } state_t;

    // PUSH and CALL grow the stack (memory write); POP and RET shrink it (memory read).
    function automatic logic is_write_op(input logic [OP_W-1:0] code);
        return (code == OP_PUSH) || (code == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_controller.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer: one memory access per operation,
// then SP writeback (and destination register for POP), with PC redirect for CALL/RET.
module stack_controller
    import stack_controller_pkg::*;
#(
    parameter logic [7:0] STACK_LIMIT = 8'h80
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_code,
    input  logic [REG_AW-1:0]   op_reg,
    input  logic [DATA_W-1:0]   op_target,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   sp_value,
    output logic [REG_AW-1:0]   rf_read_addr,
    input  logic [DATA_W-1:0]   rf_read_data,
    output logic                rf_write_en,
    output logic [REG_AW-1:0]   rf_write_addr,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                pc_load,
    output logic [DATA_W-1:0]   pc_next,
    output logic                done,
    output logic                fault
);

    state_t              state;
    logic [OP_W-1:0]     code_q;
    logic [REG_AW-1:0]   reg_q;
    logic [DATA_W-1:0]   target_q;
    logic [DATA_W-1:0]   sp_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                accept_write;
    logic                accept_reject;

    // The read port must follow op_reg combinationally so the source value is ready at accept.
    assign rf_read_addr = (state == ST_IDLE) ? op_reg : '0;

    // Bounds check on the incoming request; SP+/-1 can never wrap once it passes.
    always_comb begin
        accept_write  = is_write_op(op_code);
        accept_reject = accept_write ? (sp_value == STACK_LIMIT) : (sp_value == SP_TOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            code_q        <= '0;
            reg_q         <= '0;
            target_q      <= '0;
            sp_q          <= '0;
            rdata_q       <= '0;
            op_ready      <= 1'b1;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            pc_load       <= 1'b0;
            pc_next       <= '0;
            done          <= 1'b0;
            fault         <= 1'b0;
        end else begin
            // Strobes are single-cycle; each transition below re-asserts what the next state needs.
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            pc_load       <= 1'b0;
            pc_next       <= '0;
            done          <= 1'b0;
            fault         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        code_q   <= op_code;
                        reg_q    <= op_reg;
                        target_q <= op_target;
                        sp_q     <= sp_value;
                        op_ready <= 1'b0;
                        if (accept_reject) begin
                            state <= ST_FAULT;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state     <= ST_MEM;
                            mem_req   <= 1'b1;
                            mem_we    <= accept_write;
                            mem_addr  <= accept_write ? sp_value : DATA_W'(sp_value + 8'd1);
                            mem_wdata <= (op_code == OP_CALL) ? pc_in : rf_read_data;
                        end
                    end
                end

                ST_MEM: begin
                    if (mem_ack) begin
                        state         <= ST_WB_SP;
                        rdata_q       <= mem_rdata;
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_addr      <= '0;
                        mem_wdata     <= '0;
                        rf_write_en   <= 1'b1;
                        rf_write_addr <= SP_INDEX;
                        rf_write_data <= is_write_op(code_q) ? DATA_W'(sp_q - 8'd1)
                                                             : DATA_W'(sp_q + 8'd1);
                        if (code_q == OP_CALL) begin
                            pc_load <= 1'b1;
                            pc_next <= target_q;
                        end else if (code_q == OP_RET) begin
                            pc_load <= 1'b1;
                            pc_next <= mem_rdata;
                        end
                        done <= (code_q != OP_POP);
                    end
                end

                ST_WB_SP: begin
                    if (code_q == OP_POP) begin
                        // Register write follows SP, so POP into R3 leaves the popped value as SP.
                        state         <= ST_WB_REG;
                        rf_write_en   <= 1'b1;
                        rf_write_addr <= reg_q;
                        rf_write_data <= rdata_q;
                        done          <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        op_ready <= 1'b1;
                    end
                end

                ST_WB_REG: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end

                ST_FAULT: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/stack_controller.md
# stack_controller

Multi-cycle sequencer that executes stack instructions (PUSH, POP, CALL, RET) against the 4-entry register file and the data memory. Sits between the decode stage and the register file's write port. Reads SP from the register file's R3 (reset value 0xFF), performs one memory access per operation, and writes back SP and, for POP, the destination register. Redirects the PC for CALL and RET, and flags stack overflow and underflow without touching state.

## Interface
Parameters:
- STACK_LIMIT, 8'h80: lowest SP value at which a push is refused. Valid stack slots are STACK_LIMIT+1 .. 0xFF.

Ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- op_valid, in, 1: operation request.
- op_ready, out, 1: controller can accept an operation.
- op_code, in, 2: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- op_reg, in, 2: source register (PUSH) or destination register (POP).
- op_target, in, 8: CALL target address.
- pc_in, in, 8: return address pushed by CALL.
- sp_value, in, 8: current R3 value from the register file.
- rf_read_addr, out, 2: register file read port A address.
- rf_read_data, in, 8: register file read port A data (combinational).
- rf_write_en, out, 1: register file write enable.
- rf_write_addr, out, 2: register file write address.
- rf_write_data, out, 8: register file write data.
- mem_req, out, 1: memory request.
- mem_we, out, 1: 1 = write, 0 = read.
- mem_addr, out, 8: memory address.
- mem_wdata, out, 8: memory write data.
- mem_rdata, in, 8: memory read data, valid when mem_ack = 1.
- mem_ack, in, 1: memory completion; may arrive 0..N cycles after mem_req rises.
- pc_load, out, 1: one-cycle PC redirect strobe.
- pc_next, out, 8: PC value, valid with pc_load.
- done, out, 1: one-cycle completion pulse.
- fault, out, 1: asserted with done when the operation was rejected.

## Operation
- States: IDLE, MEM, WB_SP, WB_REG, FAULT.
- IDLE:
  - op_ready = 1 and rf_read_addr = op_reg.
  - When op_valid = 1, latch op_code, op_reg, op_target, pc_in, sp_value and rf_read_data.
- Bounds check at accept:
  - PUSH or CALL with SP == STACK_LIMIT: overflow, go to FAULT.
  - POP or RET with SP == 0xFF: underflow, go to FAULT.
  - Otherwise go to MEM.
- MEM:
  - Hold mem_req = 1 with stable mem_we, mem_addr and mem_wdata until mem_ack = 1.
  - PUSH: write latched register data to address SP.
  - CALL: write pc_in to address SP.
  - POP and RET: read from address SP+1.
  - On mem_ack, capture mem_rdata and go to WB_SP.
- WB_SP:
  - Assert rf_write_en with rf_write_addr = 3.
  - PUSH and CALL write SP-1. POP and RET write SP+1.
  - CALL: pc_load = 1, pc_next = op_target.
  - RET: pc_load = 1, pc_next = captured mem_rdata.
  - POP goes to WB_REG. All other operations assert done and go to IDLE.
- WB_REG (POP only):
  - Write the captured data to op_reg, assert done, go to IDLE.
  - POP into R3 is legal; the final SP equals the popped value.
- FAULT: assert done and fault for one cycle. No memory access and no register or PC writes. Go to IDLE.
- Arithmetic is 8-bit unsigned. The bounds check guarantees SP±1 never wraps.

## Timing
- Reset values: op_ready = 1; all other outputs 0; state IDLE.
- Reset mid-operation: all outputs drop immediately and asynchronously, and the in-flight operation is abandoned. A late mem_ack arriving after reset is ignored.
- Accept happens at the clock edge where op_valid = 1 and op_ready = 1 (cycle T). op_ready is 0 from T+1 until the cycle after done.
- Zero-wait memory (mem_ack in the first MEM cycle):
  - PUSH, CALL, RET: done at T+2.
  - POP: done at T+3.
  - Fault: done at T+1.
  - Each memory wait cycle adds 1.
- rf_write_en is never asserted in IDLE, MEM or FAULT. This leaves the write port free for the ALU writeback outside WB states.
- op_valid asserted while busy is ignored. It is not queued.

## Structure
- The shared package holds opcode localparams (OP_PUSH, OP_POP, OP_CALL, OP_RET), the state encoding, and SP_INDEX = 2'd3.
- Single module with no sub-module. The bounds check and address adder are inline.

## Test plan
- Reset with SP = 0xFF, R1 = 0x5A; PUSH R1 with mem_ack at zero wait → memory write 0x5A @0xFF; R3 = 0xFE; done at T+2.
- Following POP into R2 → memory read @0xFF returns 0x5A; R3 = 0xFF; R2 = 0x5A; done at T+3.
- CALL with pc_in = 0x12, op_target = 0x40 → memory write 0x12 @0xFF; R3 = 0xFE; pc_load with pc_next = 0x40. Then RET → pc_next = 0x12, R3 = 0xFF.
- POP at SP = 0xFF → fault and done at T+1; no mem_req, no rf_write_en. PUSH at SP = 0x80 → same fault.
- PUSH with mem_ack delayed 3 cycles → mem_req and mem_addr stable throughout; done at T+5. Pulse op_valid while busy → ignored.
- Deassert rst_n during MEM → mem_req = 0 immediately, op_ready = 1, no register write.
